issue_ctrl: RTL and testbench

Fetch/decode/issue sequencer for the TinyML RISC core. It fetches 32-bit instructions from a synchronous instruction memory and splits them into opcode/rd/rs1/rs2/imm16 fields (31:28, 27:24, 23:20, 19:16, 15:0). It issues each instruction to the execution datapath over a valid/ready handshake and stalls on multi-cycle ML ops (MAC4, CONV3, SIGMOID, ACC) until the unit reports completion. It sits between instruction memory and the execution units, and owns the program counter.

---
 rtl/isa_pkg.sv | 49 ++++
 rtl/issue_ctrl_if.sv | 21 ++
 rtl/issue_ctrl_decoder.sv | 19 +
 rtl/issue_ctrl.sv | 137 +++++++++++++
 tb/tb_issue_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// TinyML ISA definitions shared by the issue sequencer and the execution units:
// opcodes, instruction field positions and field-extraction helpers.
package isa_pkg;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_HALT    = 4'h7;
  localparam logic [3:0] OP_MAC4    = 4'h8;
  localparam logic [3:0] OP_JMP     = 4'hB;
  localparam logic [3:0] OP_CONV3   = 4'hD;
  localparam logic [3:0] OP_SIGMOID = 4'hE;
  localparam logic [3:0] OP_ACC     = 4'hF;

  localparam int OPC_LSB = 28;
  localparam int RD_LSB  = 24;
  localparam int RS1_LSB = 20;
  localparam int RS2_LSB = 16;
  localparam int IMM_LSB = 0;

  function automatic logic [3:0] f_opcode(input logic [31:0] w);
    return w[OPC_LSB +: 4];
  endfunction

  function automatic logic [3:0] f_rd(input logic [31:0] w);
    return w[RD_LSB +: 4];
  endfunction

  function automatic logic [3:0] f_rs1(input logic [31:0] w);
    return w[RS1_LSB +: 4];
  endfunction

  function automatic logic [3:0] f_rs2(input logic [31:0] w);
    return w[RS2_LSB +: 4];
  endfunction

  function automatic logic [15:0] f_imm(input logic [31:0] w);
    return w[IMM_LSB +: 16];
  endfunction

  // Ops that complete later through ex_done rather than on the handshake.
  function automatic logic is_multicycle(input logic [3:0] op);
    logic mc;
    case (op)
      OP_MAC4, OP_CONV3, OP_SIGMOID, OP_ACC: mc = 1'b1;
      default:                               mc = 1'b0;
    endcase
    return mc;
  endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Issue channel between the sequencer (master) and an execution unit (slave).
interface issue_ctrl_if;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_done;
  logic [3:0]  ex_opcode;
  logic [3:0]  ex_rd;
  logic [3:0]  ex_rs1;
  logic [3:0]  ex_rs2;
  logic [15:0] ex_imm;

  modport master (
    output ex_valid, ex_opcode, ex_rd, ex_rs1, ex_rs2, ex_imm,
    input  ex_ready, ex_done
  );

  modport slave (
    input  ex_valid, ex_opcode, ex_rd, ex_rs1, ex_rs2, ex_imm,
    output ex_ready, ex_done
  );
endinterface

// File: rtl/issue_ctrl_decoder.sv
// Splits a 32-bit instruction word into its opcode, register and immediate fields.
module decoder
  import isa_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [3:0]  opcode_o,
  output logic [3:0]  rd_o,
  output logic [3:0]  rs1_o,
  output logic [3:0]  rs2_o,
  output logic [15:0] imm_o
);

  assign opcode_o = f_opcode(instr_i);
  assign rd_o     = f_rd(instr_i);
  assign rs1_o    = f_rs1(instr_i);
  assign rs2_o    = f_rs2(instr_i);
  assign imm_o    = f_imm(instr_i);

endmodule

// File: rtl/issue_ctrl.sv
// Fetch/decode/issue sequencer: owns the PC, fetches from synchronous imem,
// issues over valid/ready and stalls on multi-cycle ops until ex_done.
module issue_ctrl
  import isa_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [31:0]        imem_rdata,
  issue_ctrl_if.master       ex,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire;
  logic               clear_cnt;

  logic [3:0]         fetch_op;
  logic [15:0]        fetch_imm;
  logic [3:0]         dec_opcode;

  // The class decision in DECODE must use the word arriving from imem this cycle.
  assign fetch_op  = f_opcode(imem_rdata);
  assign fetch_imm = f_imm(imem_rdata);

  decoder u_decoder (
    .instr_i  (instr_q),
    .opcode_o (dec_opcode),
    .rd_o     (ex.ex_rd),
    .rs1_o    (ex.ex_rs1),
    .rs2_o    (ex.ex_rs2),
    .imm_o    (ex.ex_imm)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retire    = 1'b0;
    clear_cnt = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          clear_cnt = 1'b1;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        instr_d = imem_rdata;
        case (fetch_op)
          OP_NOP: begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          OP_JMP: begin
            pc_d    = PC_W'(fetch_imm);
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          OP_HALT: begin
            state_d = S_HALT;
            retire  = 1'b1;
          end
          default: state_d = S_ISSUE;
        endcase
      end
      S_ISSUE: begin
        if (ex.ex_ready) begin
          pc_d = pc_q + PC_W'(1);
          // A done pulse coincident with the handshake completes the op at once.
          if (is_multicycle(dec_opcode) && !ex.ex_done) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (ex.ex_done) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear_cnt) begin
      retired_d = '0;
    end else if (retire && (retired_q != '1)) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign ex.ex_valid  = (state_q == S_ISSUE);
  assign ex.ex_opcode = dec_opcode;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign busy         = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                        (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign halted       = (state_q == S_HALT);
  assign retired      = retired_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: issued words are checked against a
// scoreboard queue, control/status outputs are checked at fixed cycle points.
module tb_issue_ctrl;

  localparam logic [31:0] W_HALT = 32'h7000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic [15:0] retired;

  issue_ctrl_if ex ();

  issue_ctrl #(.PC_W(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .ex         (ex.master),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  logic [31:0] sb_q [$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  function automatic logic [31:0] issue_word();
    return {ex.ex_opcode, ex.ex_rd, ex.ex_rs1, ex.ex_rs2, ex.ex_imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = W_HALT;
  endtask

  // Scoreboard consumer: every completed handshake must match the next expected word.
  logic [31:0] exp_w;
  always @(negedge clk) begin
    if (!rst && ex.ex_valid && ex.ex_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_issue", 32'(ex.ex_valid), 32'd0);
      end else begin
        exp_w = sb_q.pop_front();
        check_eq("issue_word", issue_word(), exp_w);
      end
    end
  end

  initial begin
    int n_cyc;
    int v_cnt;
    clear_mem();
    rst = 1'b1;
    start = 1'b0;
    ex.ex_ready = 1'b0;
    ex.ex_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_valid",   32'(ex.ex_valid), 32'd0);
    check_eq("rst_fields",  issue_word(), 32'd0);
    check_eq("rst_pc",      32'(pc), 32'd0);
    check_eq("rst_addr",    32'(imem_addr), 32'd0);
    check_eq("rst_busy",    32'(busy), 32'd0);
    check_eq("rst_halted",  32'(halted), 32'd0);
    check_eq("rst_retired", 32'(retired), 32'd0);

    // Single-cycle op then HALT
    mem[0] = 32'h1123_0005;
    mem[1] = W_HALT;
    sb_q.push_back(32'h1123_0005);
    ex.ex_ready = 1'b1;
    do_start();
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_addr", 32'(imem_addr), 32'd0);
    n_cyc = 0;
    v_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ex.ex_valid) v_cnt++;
      if (halted) begin
        n_cyc = i;
        break;
      end
    end
    check_eq("t1_halt_cycles", 32'(n_cyc), 32'd5);
    check_eq("t1_valid_cycles", 32'(v_cnt), 32'd1);
    check_eq("t1_retired", 32'(retired), 32'd2);
    check_eq("t1_pc", 32'(pc), 32'd1);
    check_eq("t1_busy_off", 32'(busy), 32'd0);

    // MAC4 with late ex_done; restart from HALT clears retired
    clear_mem();
    mem[0] = 32'h8000_0000;
    sb_q.push_back(32'h8000_0000);
    do_start();
    check_eq("t2_retired_clr", 32'(retired), 32'd0);
    check_eq("t2_pc_clr", 32'(pc), 32'd0);
    tick();
    tick();
    check_eq("t2_valid", 32'(ex.ex_valid), 32'd1);
    tick();
    check_eq("t2_wait_valid", 32'(ex.ex_valid), 32'd0);
    check_eq("t2_wait_pc", 32'(pc), 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("t2_wait_hold", 32'(retired), 32'd0);
    end
    ex.ex_done = 1'b1;
    tick();
    ex.ex_done = 1'b0;
    check_eq("t2_done_retired", 32'(retired), 32'd1);
    check_eq("t2_fetch_addr", 32'(imem_addr), 32'd1);
    tick();
    tick();
    check_eq("t2_halted", 32'(halted), 32'd1);
    check_eq("t2_retired_end", 32'(retired), 32'd2);

    // Backpressure: ex_ready low for 6 cycles in ISSUE
    clear_mem();
    mem[0] = 32'h3456_ABCD;
    sb_q.push_back(32'h3456_ABCD);
    ex.ex_ready = 1'b0;
    do_start();
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      check_eq("t3_hold_valid", 32'(ex.ex_valid), 32'd1);
      check_eq("t3_hold_word", issue_word(), 32'h3456_ABCD);
      check_eq("t3_hold_pc", 32'(pc), 32'd0);
      tick();
    end
    ex.ex_ready = 1'b1;
    tick();
    check_eq("t3_hs_pc", 32'(pc), 32'd1);
    check_eq("t3_hs_valid", 32'(ex.ex_valid), 32'd0);
    check_eq("t3_hs_retired", 32'(retired), 32'd1);
    tick();
    tick();
    check_eq("t3_halted", 32'(halted), 32'd1);

    // JMP to 0xFF, NOP there wraps pc to 0
    clear_mem();
    mem[0]   = 32'hB000_00FF;
    mem[255] = 32'h0000_0000;
    do_start();
    check_eq("t4_addr0", 32'(imem_addr), 32'd0);
    tick();
    tick();
    check_eq("t4_jmp_addr", 32'(imem_addr), 32'h0000_00FF);
    check_eq("t4_jmp_retired", 32'(retired), 32'd1);
    tick();
    tick();
    check_eq("t4_wrap_pc", 32'(pc), 32'd0);
    check_eq("t4_wrap_retired", 32'(retired), 32'd2);
    check_eq("t4_wrap_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t4_rst_busy", 32'(busy), 32'd0);

    // rst during ISSUE with ex_ready high: aborted, not retired
    clear_mem();
    mem[0] = 32'h2111_0001;
    ex.ex_ready = 1'b0;
    do_start();
    tick();
    tick();
    check_eq("t5_issue_valid", 32'(ex.ex_valid), 32'd1);
    ex.ex_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ex.ex_ready = 1'b0;
    check_eq("t5_rst_valid", 32'(ex.ex_valid), 32'd0);
    check_eq("t5_rst_retired", 32'(retired), 32'd0);
    check_eq("t5_rst_word", issue_word(), 32'd0);

    // start while busy ignored; rst mid-WAIT; later ex_done ignored
    clear_mem();
    mem[0] = 32'hE123_4567;
    sb_q.push_back(32'hE123_4567);
    ex.ex_ready = 1'b1;
    do_start();
    tick();
    tick();
    tick();
    do_start();
    check_eq("t6_start_pc", 32'(pc), 32'd1);
    check_eq("t6_start_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t6_rst_pc", 32'(pc), 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_halted", 32'(halted), 32'd0);
    check_eq("t6_rst_word", issue_word(), 32'd0);
    ex.ex_done = 1'b1;
    tick();
    ex.ex_done = 1'b0;
    check_eq("t6_done_ign_ret", 32'(retired), 32'd0);
    check_eq("t6_done_ign_busy", 32'(busy), 32'd0);

    // ex_done coincident with the CONV3 handshake
    clear_mem();
    mem[0] = 32'hD000_0001;
    sb_q.push_back(32'hD000_0001);
    do_start();
    tick();
    tick();
    check_eq("t7_valid", 32'(ex.ex_valid), 32'd1);
    ex.ex_done = 1'b1;
    tick();
    ex.ex_done = 1'b0;
    check_eq("t7_retired", 32'(retired), 32'd1);
    check_eq("t7_pc", 32'(pc), 32'd1);
    tick();
    tick();
    check_eq("t7_halted", 32'(halted), 32'd1);
    check_eq("t7_retired_end", 32'(retired), 32'd2);

    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
